// File: rtl/data_mem_responder_pkg.sv
// Shared types and widths for the data memory responder and its storage array.
package data_mem_responder_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_mem_array_wstrb.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module mem_array_wstrb
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [NUM_LANES-1:0]     be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rd_en,
  input  logic                     rd_clr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane write port; the array itself carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we && be[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register doubles as the response data register, so it is cleared outside load responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rdata_r <= mem_r[addr];
    end else if (rd_clr) begin
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed latency in front of a byte-enabled memory.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [ADDR_W-1:0]    req_addr_i,
  input  logic [DATA_W-1:0]    req_wdata_i,
  input  logic [NUM_LANES-1:0] req_wstrb_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DATA_W-1:0]    resp_rdata_o,
  output logic                 resp_err_o
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  logic                  write_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [NUM_LANES-1:0]  wstrb_r;
  logic                  resp_err_r;

  logic                  accept_s, enter_resp_s, leave_resp_s, err_s;
  logic                  eff_write_s;
  logic [ADDR_W-1:0]     eff_addr_s;
  logic [DATA_W-1:0]     eff_wdata_s;
  logic [NUM_LANES-1:0]  eff_wstrb_s;

  assign accept_s = req_valid_i && (state_r == ST_IDLE);

  // With LATENCY = 1 the response is produced on the accepting edge, so bypass the capture registers in IDLE.
  always_comb begin
    eff_write_s = write_r;
    eff_addr_s  = addr_r;
    eff_wdata_s = wdata_r;
    eff_wstrb_s = wstrb_r;
    if (state_r == ST_IDLE) begin
      eff_write_s = req_write_i;
      eff_addr_s  = req_addr_i;
      eff_wdata_s = req_wdata_i;
      eff_wstrb_s = req_wstrb_i;
    end else begin
      eff_write_s = write_r;
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
      eff_wstrb_s = wstrb_r;
    end
  end

  assign err_s = (eff_addr_s[1:0] != 2'b00) ||
                 (eff_addr_s[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));

  // Next-state and latency counter logic.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    enter_resp_s = 1'b0;
    leave_resp_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            state_nxt_s  = ST_RESP;
            cnt_nxt_s    = 4'd0;
            enter_resp_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s  = ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_nxt_s  = ST_IDLE;
          leave_resp_s = 1'b1;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, counter and error-flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      resp_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (enter_resp_s) begin
        resp_err_r <= err_s;
      end else if (leave_resp_s) begin
        resp_err_r <= 1'b0;
      end else begin
        resp_err_r <= resp_err_r;
      end
    end
  end

  // Request capture; only the accepting edge updates these.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      write_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      wstrb_r <= {NUM_LANES{1'b0}};
    end else if (accept_s) begin
      write_r <= req_write_i;
      addr_r  <= req_addr_i;
      wdata_r <= req_wdata_i;
      wstrb_r <= req_wstrb_i;
    end else begin
      write_r <= write_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      wstrb_r <= wstrb_r;
    end
  end

  mem_array_wstrb #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .we     (enter_resp_s && eff_write_s && !err_s),
    .be     (eff_wstrb_s),
    .addr   (eff_addr_s[AW+1:2]),
    .wdata  (eff_wdata_s),
    .rd_en  (enter_resp_s && !eff_write_s && !err_s),
    .rd_clr (enter_resp_s || leave_resp_s),
    .rdata  (resp_rdata_o)
  );

  assign req_ready_o  = (state_r == ST_IDLE);
  assign resp_valid_o = (state_r == ST_RESP);
  assign resp_err_o   = resp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench: index 0 is LATENCY=2, index 1 is LATENCY=3, index 2 is LATENCY=1.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wstrb  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .req_wstrb_i(req_wstrb[0]), .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .req_wstrb_i(req_wstrb[1]), .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_write_i(req_write[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .req_wstrb_i(req_wstrb[2]), .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready[2]),
    .resp_rdata_o(resp_rdata[2]), .resp_err_o(resp_err[2]));

  // Present a request for one edge (responder assumed idle), then drop req_valid.
  task automatic start_req(input int k, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    req_valid[k] = 1'b1; req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_wstrb[k] = s;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  // Count edges after acceptance until resp_valid is seen; bounded.
  task automatic wait_resp(input int k, output int lat);
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      lat++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!resp_valid[k]) begin
      n_fail++;
      $display("FAIL resp_timeout dut%0d: resp_valid=%b required 1", k, resp_valid[k]);
    end
  endtask

  task automatic ack_resp(input int k);
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
  endtask

  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
    start_req(k, w, a, d, s);
    wait_resp(k, lat);
    rd = resp_rdata[k];
    er = resp_err[k];
    ack_resp(k);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 ||
          resp_rdata[k] !== 32'h0 || resp_err[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                 k, req_ready[k], resp_valid[k], resp_rdata[k], resp_err[k]);
      end
    end
  endtask

  task automatic test_store_basic();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d required 2", lat); end
    n_checks++;
    if (er !== 1'b0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL store_resp: err=%b rdata=%h required 0 00000000", er, rd);
    end
  endtask

  task automatic test_byte_strobe();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
    txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d required 2", lat); end
    n_checks++;
    if (rd !== 32'hDEADBEAA || er !== 1'b0) begin
      n_fail++; $display("FAIL byte_merge: rdata=%h err=%b required deadbeaa 0", rd, er);
    end
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
    txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL noop_store: rdata=%h required deadbeaa", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(0, 1'b0, 32'h13, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL misaligned_load: err=%b rdata=%h required 1 00000000", er, rd);
    end
    txn(0, 1'b1, 32'h0, 32'h11223344, 4'b1111, rd, er, lat);
    txn(0, 1'b1, 32'(4 * DEPTH), 32'hFFFFFFFF, 4'b1111, rd, er, lat);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL range_store: err=%b rdata=%h required 1 00000000", er, rd);
    end
    txn(0, 1'b0, 32'h0, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      n_fail++; $display("FAIL word0_intact: rdata=%h err=%b required 11223344 0", rd, er);
    end
    txn(0, 1'b1, 32'h16, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
    txn(0, 1'b0, 32'h14, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (rd === 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL misaligned_store_wrote: rdata=%h required not ffffffff", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    start_req(0, 1'b0, 32'h10, 32'h0, 4'b0000);
    wait_resp(0, lat);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10;
    req_wdata[0] = 32'h0; req_wstrb[0] = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEADBEAA || req_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable c%0d: valid=%b rdata=%h ready=%b required 1 deadbeaa 0",
                 i, resp_valid[0], resp_rdata[0], req_ready[0]);
      end
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    n_checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL release: ready=%b valid=%b required 1 0", req_ready[0], resp_valid[0]);
    end
    txn(0, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (rd !== 32'hDEADBEAA) begin
      n_fail++; $display("FAIL ignored_inputs: rdata=%h required deadbeaa", rd);
    end
  endtask

  task automatic test_reset_resp();
    int lat;
    start_req(0, 1'b0, 32'h10, 32'h0, 4'b0000);
    wait_resp(0, lat);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 ||
        resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_resp: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               req_ready[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    end
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd; logic er; int lat; logic seen;
    txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, rd, er, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL lat3_latency: got %0d required 3", lat); end
    start_req(1, 1'b1, 32'h20, 32'h12345678, 4'b1111);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0 ||
        resp_rdata[1] !== 32'h0 || resp_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
               req_ready[1], resp_valid[1], resp_rdata[1], resp_err[1]);
    end
    @(posedge clk); #3 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid[1] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL abandoned_resp: seen=%b required 0", seen); end
    txn(1, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
    n_checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      n_fail++; $display("FAIL abandoned_store: rdata=%h err=%b required cafef00d 0", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic        wr_v [4];
    logic [31:0] ad_v [4];
    logic [31:0] wd_v [4];
    logic [31:0] ex_v [4];
    int acc_cyc[$];
    int idx;
    int n_resp;
    logic acc;
    wr_v = '{1'b1, 1'b0, 1'b1, 1'b0};
    ad_v = '{32'h4, 32'h4, 32'h8, 32'h8};
    wd_v = '{32'h0A0B0C0D, 32'h0, 32'h00000055, 32'h0};
    ex_v = '{32'h0, 32'h0A0B0C0D, 32'h0, 32'h00000055};
    idx = 0; n_resp = 0;
    req_valid[2] = 1'b1; req_write[2] = wr_v[0]; req_addr[2] = ad_v[0];
    req_wdata[2] = wd_v[0]; req_wstrb[2] = 4'b1111;
    resp_ready[2] = 1'b1;
    for (int c = 0; c < 16 && n_resp < 4; c++) begin
      @(negedge clk);
      if (resp_valid[2] === 1'b1) begin
        n_checks++;
        if (resp_rdata[2] !== ex_v[n_resp] || resp_err[2] !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_resp%0d: rdata=%h err=%b required %h 0",
                   n_resp, resp_rdata[2], resp_err[2], ex_v[n_resp]);
        end
        n_resp++;
      end
      acc = req_ready[2] && req_valid[2];
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc.push_back(c);
        idx++;
        if (idx < 4) begin
          req_write[2] = wr_v[idx]; req_addr[2] = ad_v[idx]; req_wdata[2] = wd_v[idx];
        end else begin
          req_valid[2] = 1'b0;
        end
      end
    end
    resp_ready[2] = 1'b0;
    n_checks++;
    if (acc_cyc.size() != 4 || n_resp != 4) begin
      n_fail++;
      $display("FAIL b2b_count: accepts=%0d responses=%0d required 4 4", acc_cyc.size(), n_resp);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      n_checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
        n_fail++;
        $display("FAIL b2b_spacing%0d: got %0d required 2", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 32'h0;
      req_wdata[k] = 32'h0; req_wstrb[k] = 4'b0000; resp_ready[k] = 1'b0;
    end
    #2;
    test_reset();
    #10 rst = 1'b1;
    @(posedge clk); #1;
    test_store_basic();
    test_byte_strobe();
    test_errors();
    test_backpressure();
    test_reset_resp();
    test_reset_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
